bsg_counter_bank: RTL

BSG_COUNTER_BANK -- requirements
Module: bsg_counter_bank

---
 rtl/bsg_counter_bank.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/bsg_counter_bank.sv
// bsg_counter_bank
//
// Bank of els_p independent width_p-bit event counters. Each counter has a
// sticky overflow flag. Counters are read through a valid/ready request
// channel and answered on a registered valid/yumi response channel.
//
// Build option: define BSG_COUNTER_BANK_SNAPSHOT_EN to add shadow registers.
// With it, snap_i copies every counter and overflow flag into the shadow
// registers, and reads return the shadow copy. Without it, snap_i is ignored
// and reads return the live counters.
//
// Parameters
//   width_p    : counter width in bits
//   els_p      : number of counter channels (1..64)
//   saturate_p : 0 = wrap to zero on overflow, 1 = hold at all-ones
//
// Ports
//   clk_i      : clock, rising edge
//   reset_i    : asynchronous active-high reset
//   en_i       : global count enable
//   inc_i      : per-channel increment strobes (gated by en_i)
//   clear_i    : synchronous clear of all counters and overflow flags
//   snap_i     : snapshot strobe (snapshot build only)
//   rd_v_i     : read request valid
//   rd_addr_i  : channel to read; out-of-range reads return zero
//   rd_clr_i   : clear the addressed channel when the read is accepted
//   rd_ready_o : request may be accepted
//   rd_v_o     : response valid
//   rd_data_o  : response counter value
//   rd_ovf_o   : response overflow flag
//   rd_yumi_i  : response consumed
//   ovf_o      : live sticky overflow flags
module bsg_counter_bank #(
  parameter int width_p    = 32,
  parameter int els_p      = 4,
  parameter int saturate_p = 0,
  localparam int addr_w_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic [els_p-1:0]     inc_i,
  input  logic                 clear_i,
  input  logic                 snap_i,
  input  logic                 rd_v_i,
  input  logic [addr_w_lp-1:0] rd_addr_i,
  input  logic                 rd_clr_i,
  output logic                 rd_ready_o,
  output logic                 rd_v_o,
  output logic [width_p-1:0]   rd_data_o,
  output logic                 rd_ovf_o,
  input  logic                 rd_yumi_i,
  output logic [els_p-1:0]     ovf_o
);

  logic [width_p-1:0] cnt_q [els_p];
  logic [width_p-1:0] cnt_d [els_p];
  logic [els_p-1:0]   ovf_q, ovf_d;

  logic               rd_v_q, rd_v_d;
  logic [width_p-1:0] rd_data_q, rd_data_d;
  logic               rd_ovf_q, rd_ovf_d;

  logic               accept;
  logic [width_p-1:0] sel_data;
  logic               sel_ovf;

  // The response slot can take a new request when empty or being drained.
  assign rd_ready_o = ~rd_v_q | rd_yumi_i;
  assign accept     = rd_v_i & rd_ready_o;

`ifdef BSG_COUNTER_BANK_SNAPSHOT_EN
  logic [width_p-1:0] snap_cnt_q [els_p];
  logic [width_p-1:0] snap_cnt_d [els_p];
  logic [els_p-1:0]   snap_ovf_q, snap_ovf_d;

  // Shadow copy takes the pre-increment live values on a snapshot strobe.
  always_comb begin
    snap_ovf_d = snap_ovf_q;
    for (int i = 0; i < els_p; i++) begin
      snap_cnt_d[i] = snap_cnt_q[i];
    end
    if (snap_i) begin
      snap_ovf_d = ovf_q;
      for (int i = 0; i < els_p; i++) begin
        snap_cnt_d[i] = cnt_q[i];
      end
    end else begin
      snap_ovf_d = snap_ovf_q;
    end
  end

  // Shadow registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      snap_ovf_q <= '0;
      for (int i = 0; i < els_p; i++) begin
        snap_cnt_q[i] <= '0;
      end
    end else begin
      snap_ovf_q <= snap_ovf_d;
      for (int i = 0; i < els_p; i++) begin
        snap_cnt_q[i] <= snap_cnt_d[i];
      end
    end
  end
`else
  logic unused_snap;
  assign unused_snap = snap_i;
`endif

  // Read mux. An out-of-range address matches no channel, so it reads zero.
  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      if (rd_addr_i == addr_w_lp'(i)) begin
`ifdef BSG_COUNTER_BANK_SNAPSHOT_EN
        sel_data = snap_cnt_q[i];
        sel_ovf  = snap_ovf_q[i];
`else
        sel_data = cnt_q[i];
        sel_ovf  = ovf_q[i];
`endif
      end else begin
        sel_data = sel_data;
        sel_ovf  = sel_ovf;
      end
    end
  end

  // Next counter state: apply the read-clear first, then the increment,
  // so an event that coincides with a read-clear is kept (result 1).
  // A global clear overrides both.
  always_comb begin
    logic               clr_ch;
    logic [width_p-1:0] base_cnt;
    logic               base_ovf;
    clr_ch   = 1'b0;
    base_cnt = '0;
    base_ovf = 1'b0;
    ovf_d    = ovf_q;
    for (int i = 0; i < els_p; i++) begin
      clr_ch   = accept & rd_clr_i & (rd_addr_i == addr_w_lp'(i));
      base_cnt = clr_ch ? '0 : cnt_q[i];
      base_ovf = clr_ch ? 1'b0 : ovf_q[i];
      cnt_d[i] = base_cnt;
      ovf_d[i] = base_ovf;
      if (en_i & inc_i[i]) begin
        if (&base_cnt) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (saturate_p != 0) ? '1 : '0;
        end else begin
          cnt_d[i] = base_cnt + width_p'(1);
        end
      end else begin
        cnt_d[i] = base_cnt;
      end
      if (clear_i) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else begin
        ovf_d[i] = ovf_d[i];
      end
    end
  end

  // Response slot: load on accept, drop on yumi, otherwise hold.
  always_comb begin
    rd_v_d    = rd_v_q;
    rd_data_d = rd_data_q;
    rd_ovf_d  = rd_ovf_q;
    if (accept) begin
      rd_v_d    = 1'b1;
      rd_data_d = sel_data;
      rd_ovf_d  = sel_ovf;
    end else if (rd_yumi_i) begin
      rd_v_d = 1'b0;
    end else begin
      rd_v_d = rd_v_q;
    end
  end

  // Counter, overflow and response registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ovf_q     <= '0;
      rd_v_q    <= 1'b0;
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
      for (int i = 0; i < els_p; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ovf_q     <= ovf_d;
      rd_v_q    <= rd_v_d;
      rd_data_q <= rd_data_d;
      rd_ovf_q  <= rd_ovf_d;
      for (int i = 0; i < els_p; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_v_o    = rd_v_q;
  assign rd_data_o = rd_data_q;
  assign rd_ovf_o  = rd_ovf_q;
  assign ovf_o     = ovf_q;

endmodule
